bcrypt_phase_seq: RTL and testbench
===================================

# bcrypt_phase_seq

Phase sequencer for the EksBlowfish core: on `start` it steps the Blowfish datapath through the following command sequence:
- state init;
- the salted key expansion;
- 2^cost alternating key-only and salt-only expansions;
- the 64-fold encryption of the "OrpheanBeholderScryDoubt" ciphertext.

It issues one command at a time over a valid/ready handshake, waits for the datapath's completion pulse, and owns the cost loop counter. It sits between `load_costsaltkey` and the `bcrypt` datapath/SRAM controllers.

## Interface
Parameters:
- `ENC_ROUNDS`, 64, number of ciphertext encryption commands.
- `MIN_COST`, 4, smallest accepted cost.
- `MAX_COST`, 31, largest accepted cost.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst_l`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a hash; sampled only in IDLE.
- `cost`  in  6  log2 iteration count; latched with `start`.
- `abort`  in  1  synchronous cancel; return to IDLE.
- `cmd_valid`  out  1  command offered to datapath.
- `cmd_op`  out  3  command opcode (`op_e`).
- `cmd_ready`  in  1  datapath accepts command when high with `cmd_valid`.
- `cmd_done`  in  1  one-cycle pulse: accepted command finished.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: hash complete.
- `cost_err`  out  1  one-cycle pulse: `start` with out-of-range cost.
- `iter_cnt`  out  32  completed key/salt expansion pairs.
- `enc_cnt`  out  7  completed encryption commands.

## Operation
- Opcodes (`op_e`):
  - `OP_INIT` = 0: load P/S constants.
  - `OP_EXP_SK` = 1: expand with salt and key.
  - `OP_EXP_K` = 2: expand with key only.
  - `OP_EXP_S` = 3: expand with salt only.
  - `OP_ENC` = 4: encrypt the 3 ctext blocks once.
- States: IDLE, INIT, EXP_SK, EXP_K, EXP_S, ENC, FIN.
- Each non-IDLE/FIN state has two phases, tracked by the `issued` flag:
  - ISSUE: `cmd_valid`=1 until the handshake `cmd_valid & cmd_ready` completes.
  - WAIT: `cmd_valid`=0 until `cmd_done`.
- IDLE with `start`:
  - If MIN_COST ≤ `cost` ≤ MAX_COST: latch cost, clear `iter_cnt` and `enc_cnt`, go to INIT.
  - Otherwise: pulse `cost_err`, stay in IDLE.
- Transitions, each taken on `cmd_done` in WAIT:
  - INIT → EXP_SK.
  - EXP_SK → EXP_K.
  - EXP_K → EXP_S.
  - EXP_S: increment `iter_cnt`. If the new value == 2^cost_latched, go to ENC; otherwise go to EXP_K.
  - ENC: increment `enc_cnt`. If the new value == ENC_ROUNDS, go to FIN; otherwise stay in ENC and re-enter ISSUE.
- FIN → IDLE; `done`=1 for that one cycle.
- Iteration target is computed as `32'd1 << cost_latched`; cost 31 gives 2^31, which fits in 32 bits without overflow.
- Total commands per hash: 2 + 2·2^cost + ENC_ROUNDS.

## Timing
- Reset values: state IDLE, `cmd_valid`=0, `cmd_op`=OP_INIT, `busy`=0, `done`=0, `cost_err`=0, `iter_cnt`=0, `enc_cnt`=0, `issued`=0.
- `start` in cycle N → INIT entered at N+1 with `cmd_valid`=1 in N+1 (registered output).
- Handshake completes in cycle M → `cmd_valid`=0 in M+1. `cmd_op` is stable while `cmd_valid` is high.
- `cmd_done` in cycle D (WAIT) → next state entered at D+1, and its `cmd_valid`=1 in D+1. There are no bubble cycles.
- `cmd_done` must arrive at least one cycle after acceptance. A `cmd_done` seen in ISSUE or IDLE is ignored.
- `start` while `busy` is ignored; latched cost does not change.
- `abort` has priority over every other event, including `cmd_done` and `start` in the same cycle:
  - next cycle is IDLE with `cmd_valid`=0;
  - no `done` pulse;
  - counters hold their values until the next `start`.
- `rst_l`=0 overrides `abort`; all outputs return to reset values on the next edge.
- `done` and `cost_err` never assert in the same cycle.

## Structure
- Shared `bcrypt_pkg` holds:
  - `op_e` (3-bit opcode enum);
  - `seq_state_e`;
  - constants `BF_CTEXT_WORDS`=6 and `BF_DEFAULT_ENC_ROUNDS`=64.
  The datapath decoder imports the same package.
- One sub-module, `bcrypt_iter_cnt`:
  - 32-bit counter with clear, increment, and a registered `hit` output meaning `count+1 == 1<<cost`;
  - instantiated for the cost loop;
  - `enc_cnt` is a plain local counter.

## Test plan
- Cost 4, datapath model with `cmd_ready`=1 and `cmd_done` 3 cycles after accept → exactly 98 commands in order INIT, EXP_SK, (EXP_K, EXP_S)×16, ENC×64. `iter_cnt`=16, `enc_cnt`=64, single `done` pulse, then `busy`=0.
- `start` with cost 3, then with cost 32 → `cost_err` pulses each time, `busy` stays 0, no `cmd_valid`.
- Cost 4 with `cmd_ready` held low for 5 cycles on each issue → `cmd_valid` and `cmd_op` held stable throughout; sequence and command count unchanged (98).
- `abort` coincident with `cmd_done` during the 7th EXP_S → IDLE next cycle, no `done`, `iter_cnt`=6. A subsequent `start` with cost 5 runs 130 commands.
- Spurious `cmd_done` during ISSUE, and `start` pulses while busy → no state change; command count and `done` timing identical to the clean run.
- `rst_l`=0 for one cycle in the middle of ENC (`enc_cnt`=20) → all outputs at reset values on the next edge; the following run completes normally.

Source files
------------

// File: rtl/bcrypt_pkg.sv
// Shared definitions for the EksBlowfish sequencer and the datapath decoder.
package bcrypt_pkg;

  typedef enum logic [2:0] {
    OP_INIT   = 3'd0,
    OP_EXP_SK = 3'd1,
    OP_EXP_K  = 3'd2,
    OP_EXP_S  = 3'd3,
    OP_ENC    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_EXP_SK,
    ST_EXP_K,
    ST_EXP_S,
    ST_ENC,
    ST_FIN
  } seq_state_e;

  localparam int BF_CTEXT_WORDS        = 6;
  localparam int BF_DEFAULT_ENC_ROUNDS = 64;

  // Command each command-issuing state offers to the datapath.
  function automatic op_e state_op(input seq_state_e s);
    case (s)
      ST_INIT:   return OP_INIT;
      ST_EXP_SK: return OP_EXP_SK;
      ST_EXP_K:  return OP_EXP_K;
      ST_EXP_S:  return OP_EXP_S;
      ST_ENC:    return OP_ENC;
      default:   return OP_INIT;
    endcase
  endfunction

endpackage

// File: rtl/bcrypt_iter_cnt.sv
// Cost-loop counter: counts completed key/salt expansion pairs and flags,
// one cycle ahead, that the next increment reaches 2^cost.
module bcrypt_iter_cnt
  import bcrypt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        clr,
  input  logic [4:0]  clr_cost,
  input  logic        inc,
  output logic [31:0] count,
  output logic        hit
);

  logic [31:0] target;

  // Clear latches the new target; hit always reflects count+1 == target.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      count  <= '0;
      target <= '0;
      hit    <= 1'b0;
    end else if (clr) begin
      count  <= '0;
      target <= 32'd1 << clr_cost;
      hit    <= (clr_cost == 5'd0);
    end else if (inc) begin
      count  <= count + 32'd1;
      hit    <= ((count + 32'd2) == target);
    end
  end

endmodule

// File: rtl/bcrypt_phase_seq.sv
// EksBlowfish phase sequencer: walks the datapath through init, salted
// expansion, 2^cost key/salt expansion pairs and the ciphertext encryptions,
// one command at a time over a valid/ready handshake.
module bcrypt_phase_seq
  import bcrypt_pkg::*;
#(
  parameter int ENC_ROUNDS = BF_DEFAULT_ENC_ROUNDS,
  parameter int MIN_COST   = 4,
  parameter int MAX_COST   = 31
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        start,
  input  logic [5:0]  cost,
  input  logic        abort,
  output logic        cmd_valid,
  output op_e         cmd_op,
  input  logic        cmd_ready,
  input  logic        cmd_done,
  output logic        busy,
  output logic        done,
  output logic        cost_err,
  output logic [31:0] iter_cnt,
  output logic [6:0]  enc_cnt
);

  localparam logic [6:0] ENC_LAST = 7'(ENC_ROUNDS);

  seq_state_e state;
  seq_state_e next_state;
  logic       issued;
  logic       cost_ok;
  logic       iter_clr;
  logic       iter_inc;
  logic       iter_hit;
  logic       enc_last;

  assign cost_ok  = (cost >= 6'(MIN_COST)) && (cost <= 6'(MAX_COST));
  assign iter_clr = !abort && (state == ST_IDLE) && start && cost_ok;
  assign iter_inc = !abort && (state == ST_EXP_S) && issued && cmd_done;
  assign enc_last = ((enc_cnt + 7'd1) == ENC_LAST);

  bcrypt_iter_cnt u_iter_cnt (
    .clk      (clk),
    .rst_l    (rst_l),
    .clr      (iter_clr),
    .clr_cost (cost[4:0]),
    .inc      (iter_inc),
    .count    (iter_cnt),
    .hit      (iter_hit)
  );

  // Where a command-issuing state goes once its command completes.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_INIT:   next_state = ST_EXP_SK;
      ST_EXP_SK: next_state = ST_EXP_K;
      ST_EXP_K:  next_state = ST_EXP_S;
      ST_EXP_S:  next_state = iter_hit ? ST_ENC : ST_EXP_K;
      ST_ENC:    next_state = enc_last ? ST_FIN : ST_ENC;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Sequencer FSM with registered handshake and status outputs; abort wins
  // over everything except reset and leaves the counters untouched.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= ST_IDLE;
      issued    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_INIT;
      busy      <= 1'b0;
      done      <= 1'b0;
      cost_err  <= 1'b0;
      enc_cnt   <= '0;
    end else begin
      done     <= 1'b0;
      cost_err <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        issued    <= 1'b0;
        cmd_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (cost_ok) begin
                state     <= ST_INIT;
                issued    <= 1'b0;
                cmd_valid <= 1'b1;
                cmd_op    <= OP_INIT;
                busy      <= 1'b1;
                enc_cnt   <= '0;
              end else begin
                cost_err <= 1'b1;
              end
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            if (!issued) begin
              if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                issued    <= 1'b1;
              end
            end else if (cmd_done) begin
              issued <= 1'b0;
              state  <= next_state;
              if (state == ST_ENC) begin
                enc_cnt <= enc_cnt + 7'd1;
              end
              if (next_state == ST_FIN) begin
                cmd_valid <= 1'b0;
                done      <= 1'b1;
              end else begin
                cmd_valid <= 1'b1;
                cmd_op    <= state_op(next_state);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcrypt_phase_seq.sv
// Self-checking bench for bcrypt_phase_seq: a datapath responder with
// configurable ready/done timing, and a reference command list built from the
// cost value.
module tb_bcrypt_phase_seq;
  import bcrypt_pkg::*;

  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cost = '0;
  logic        abort = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_done = 1'b0;
  logic        cmd_valid;
  op_e         cmd_op;
  logic        busy;
  logic        done;
  logic        cost_err;
  logic [31:0] iter_cnt;
  logic [6:0]  enc_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder configuration and state, shared with the main sequence.
  int   ready_hold = 0;
  bit   ready_rand = 0;
  int   done_lat   = 3;
  bit   lat_rand   = 0;
  bit   spur_en    = 0;
  int   wait_left  = 0;
  int   cnt        = 0;
  bit   pend       = 0;
  bit   prev_valid = 0;
  bit   prev_acc   = 0;
  logic [2:0] prev_op = '0;
  logic [2:0] last_acc_op = '0;
  int   exps_acc    = 0;
  int   done_pulses = 0;
  int   err_pulses  = 0;
  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];

  bcrypt_phase_seq dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .cost      (cost),
    .abort     (abort),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .cmd_done  (cmd_done),
    .busy      (busy),
    .done      (done),
    .cost_err  (cost_err),
    .iter_cnt  (iter_cnt),
    .enc_cnt   (enc_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference command list for one hash at the given cost.
  task automatic buildExpected(input int c);
    exp_q.delete();
    exp_q.push_back(OP_INIT);
    exp_q.push_back(OP_EXP_SK);
    for (int i = 0; i < (1 << c); i++) begin
      exp_q.push_back(OP_EXP_K);
      exp_q.push_back(OP_EXP_S);
    end
    for (int i = 0; i < 64; i++) exp_q.push_back(OP_ENC);
  endtask

  task automatic compareOps(input string tag);
    int bad;
    int n;
    bad = -1;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    checkOutput({tag, "_cmd_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    end
    checkOutput({tag, "_first_bad_op_index"}, bad, -1);
  endtask

  task automatic flushResponder();
    pend = 0;
    cnt = 0;
    wait_left = ready_rand ? int'($urandom_range(0, 3)) : ready_hold;
    prev_valid = 0;
    prev_acc = 0;
    exps_acc = 0;
    got_q.delete();
  endtask

  task automatic kick(input logic [5:0] c);
    @(negedge clk); #1;
    start = 1'b1;
    cost = c;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Starts a hash and waits for done; cyc counts cycles from the start edge.
  task automatic applyStimulus(input logic [5:0] c, input bit noise, output int cyc);
    kick(c);
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (noise) begin
        start = ($urandom_range(0, 5) == 0);
        cost = 6'($urandom_range(0, 63));
      end
      @(negedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1'b1);
  endtask

  // Datapath model: accepts commands, pulses cmd_done after a latency and
  // checks that an offered command does not change while it waits.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_pulses++;
      if (cost_err === 1'b1) err_pulses++;
      cmd_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          cmd_done = 1'b1;
          pend = 0;
        end
      end
      if (prev_valid && !prev_acc && cmd_valid === 1'b1)
        checkOutput("cmd_op_stable", cmd_op, prev_op);
      if (spur_en && cmd_valid === 1'b1 && !pend && !cmd_done && $urandom_range(0, 1) == 1)
        cmd_done = 1'b1;
      prev_valid = (cmd_valid === 1'b1);
      prev_op = cmd_op;
      prev_acc = 0;
      cmd_ready = 1'b0;
      if (cmd_valid === 1'b1) begin
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          cmd_ready = 1'b1;
          prev_acc = 1;
          got_q.push_back(cmd_op);
          last_acc_op = cmd_op;
          if (cmd_op == OP_EXP_S) exps_acc++;
          pend = 1;
          cnt = lat_rand ? int'($urandom_range(1, 4)) : done_lat;
          wait_left = ready_rand ? int'($urandom_range(0, 3)) : ready_hold;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of scenarios.
  initial begin
    int cyc;
    int clean_cyc;
    int dp0;
    int ep0;
    int k;
    int c;
    logic [5:0] bad_costs[4];

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_cmd_valid", cmd_valid, 1'b0);
    checkOutput("rst_cmd_op", cmd_op, OP_INIT);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_cost_err", cost_err, 1'b0);
    checkOutput("rst_iter_cnt", iter_cnt, 0);
    checkOutput("rst_enc_cnt", enc_cnt, 0);
    rst_l = 1'b1;

    // Clean cost-4 run, ready always high, done 3 cycles after accept.
    $display("[TB] clean cost 4 run");
    ready_hold = 0; ready_rand = 0; done_lat = 3; lat_rand = 0;
    flushResponder();
    buildExpected(4);
    dp0 = done_pulses; ep0 = err_pulses;
    applyStimulus(6'd4, 1'b0, cyc);
    clean_cyc = cyc;
    checkOutput("clean_done_cycle", cyc, exp_q.size() * (1 + done_lat) + 1);
    checkOutput("clean_busy_at_done", busy, 1'b1);
    @(negedge clk); #1;
    compareOps("clean");
    checkOutput("clean_iter_cnt", iter_cnt, 16);
    checkOutput("clean_enc_cnt", enc_cnt, 64);
    checkOutput("clean_done_pulses", done_pulses - dp0, 1);
    checkOutput("clean_err_pulses", err_pulses - ep0, 0);
    checkOutput("clean_busy_after", busy, 1'b0);
    checkOutput("clean_done_after", done, 1'b0);

    // Out-of-range costs.
    $display("[TB] cost range errors");
    bad_costs[0] = 6'd3;
    bad_costs[1] = 6'd32;
    bad_costs[2] = 6'($urandom_range(0, 3));
    bad_costs[3] = 6'($urandom_range(32, 63));
    flushResponder();
    for (int i = 0; i < 4; i++) begin
      kick(bad_costs[i]);
      checkOutput("err_pulse", cost_err, 1'b1);
      checkOutput("err_busy", busy, 1'b0);
      checkOutput("err_cmd_valid", cmd_valid, 1'b0);
      checkOutput("err_done", done, 1'b0);
      @(negedge clk); #1;
      checkOutput("err_pulse_end", cost_err, 1'b0);
      checkOutput("err_cmd_valid_after", cmd_valid, 1'b0);
    end
    checkOutput("err_no_commands", got_q.size(), 0);

    // Ready held low for 5 cycles on every issue.
    $display("[TB] ready back-pressure run");
    ready_hold = 5;
    flushResponder();
    buildExpected(4);
    dp0 = done_pulses;
    applyStimulus(6'd4, 1'b0, cyc);
    checkOutput("stall_done_cycle", cyc, exp_q.size() * (1 + 5 + done_lat) + 1);
    @(negedge clk); #1;
    compareOps("stall");
    checkOutput("stall_iter_cnt", iter_cnt, 16);
    checkOutput("stall_done_pulses", done_pulses - dp0, 1);

    // Abort together with cmd_done of the 7th EXP_S, random timing.
    $display("[TB] abort during expansion");
    ready_hold = 0; ready_rand = 1; lat_rand = 1;
    flushResponder();
    dp0 = done_pulses;
    kick(6'd4);
    k = 0;
    while (!(cmd_done === 1'b1 && last_acc_op == OP_EXP_S && exps_acc == 7) && k < LIMIT) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput("abort_point_reached", (k < LIMIT), 1'b1);
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_cmd_valid", cmd_valid, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_iter_cnt", iter_cnt, 6);
    flushResponder();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("abort_iter_hold", iter_cnt, 6);
    checkOutput("abort_no_done", done_pulses - dp0, 0);
    checkOutput("abort_idle_no_cmds", got_q.size(), 0);
    buildExpected(5);
    dp0 = done_pulses;
    applyStimulus(6'd5, 1'b0, cyc);
    @(negedge clk); #1;
    compareOps("after_abort");
    checkOutput("after_abort_iter_cnt", iter_cnt, 32);
    checkOutput("after_abort_enc_cnt", enc_cnt, 64);
    checkOutput("after_abort_done_pulses", done_pulses - dp0, 1);

    // Spurious cmd_done in ISSUE and start pulses while busy.
    $display("[TB] noise run");
    ready_rand = 0; lat_rand = 0; ready_hold = 0; done_lat = 3; spur_en = 1;
    flushResponder();
    buildExpected(4);
    dp0 = done_pulses; ep0 = err_pulses;
    applyStimulus(6'd4, 1'b1, cyc);
    spur_en = 0;
    checkOutput("noise_done_cycle", cyc, clean_cyc);
    @(negedge clk); #1;
    compareOps("noise");
    checkOutput("noise_iter_cnt", iter_cnt, 16);
    checkOutput("noise_done_pulses", done_pulses - dp0, 1);
    checkOutput("noise_err_pulses", err_pulses - ep0, 0);

    // Reset in the middle of ENC, then a normal run at a random cost.
    $display("[TB] reset during encryption");
    ready_rand = 1; lat_rand = 1;
    flushResponder();
    kick(6'd4);
    k = 0;
    while (enc_cnt !== 7'd20 && k < LIMIT) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput("enc20_reached", (k < LIMIT), 1'b1);
    rst_l = 1'b0;
    @(negedge clk); #1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_cmd_valid", cmd_valid, 1'b0);
    checkOutput("mid_rst_cmd_op", cmd_op, OP_INIT);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_cost_err", cost_err, 1'b0);
    checkOutput("mid_rst_iter_cnt", iter_cnt, 0);
    checkOutput("mid_rst_enc_cnt", enc_cnt, 0);
    rst_l = 1'b1;
    flushResponder();
    c = int'($urandom_range(4, 6));
    buildExpected(c);
    dp0 = done_pulses;
    applyStimulus(6'(c), 1'b0, cyc);
    @(negedge clk); #1;
    compareOps("after_rst");
    checkOutput("after_rst_iter_cnt", iter_cnt, 1 << c);
    checkOutput("after_rst_enc_cnt", enc_cnt, 64);
    checkOutput("after_rst_done_pulses", done_pulses - dp0, 1);
    checkOutput("after_rst_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
